instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage between the word-addressed external instruction memory and the decode stage.
- Holds the PC and drives word address and read enable to the memory.
- Waits a fixed number of memory wait states, captures the instruction, and presents it to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump) from downstream that squashes any in-flight or held fetch.

Parameters:
- MEM_WIDTH, 32, instruction word width; equals the memory word width.
- MEM_SIZE, 256, memory depth in words. Address width AW = $clog2(MEM_SIZE).
- RESET_PC, 32'h0000_0350, byte address loaded at reset (word 212).
- WAIT_CYCLES, 1, memory wait states before mem_read_val is sampled; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- fetch_en  in  1  permits new fetches.
- redirect_valid  in  1  one-cycle request to load redirect_pc.
- redirect_pc  in  32  byte target address; bits [1:0] are ignored.
- if_valid  out  1  if_instr/if_pc hold a fetched instruction.
- if_instr  out  MEM_WIDTH  fetched instruction.
- if_pc  out  32  byte address of if_instr.
- if_ready  in  1  decode accepts the instruction when if_valid && if_ready.
- mem_addr  out  AW  word address = pc[AW+1:2].
- mem_read_en  out  1  high only in FETCH.
- mem_write_en  out  1  constant 0.
- mem_write_val  out  MEM_WIDTH  constant 0.
- mem_read_val  in  MEM_WIDTH  memory read data.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = IDLE; wait counter cnt = 0.
  - if_valid = 0, if_instr = 0, if_pc = 0.
  - mem_read_en = 0; mem_addr = RESET_PC[AW+1:2].
- FSM states: IDLE, FETCH, OUT. mem_read_en = (state == FETCH), combinational. mem_addr is combinational from pc and stays stable throughout FETCH.
- IDLE:
  - fetch_en=1 -> FETCH with cnt=0.
  - Otherwise stay in IDLE.
- FETCH:
  - cnt != WAIT_CYCLES: cnt += 1.
  - cnt == WAIT_CYCLES:
    - if_instr <= mem_read_val; if_pc <= pc; if_valid <= 1.
    - pc <= pc + 4; cnt <= 0.
    - state -> OUT.
  - Fetch latency from entry into FETCH to if_valid is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0 the data is captured on the first FETCH cycle.
- FETCH with fetch_en low:
  - The fetch is abandoned, pc is unchanged, cnt <= 0, state -> IDLE.
  - fetch_en is ignored on the capture cycle; that capture completes.
- OUT:
  - if_valid, if_instr and if_pc stay stable until the handshake.
  - On if_ready: if_valid <= 0, and state -> FETCH (cnt=0) if fetch_en, else IDLE.
  - if_ready while if_valid=0 has no effect.
- Redirect has the highest priority and applies in any state, including the capture cycle and the handshake cycle:
  - pc <= {redirect_pc[31:2], 2'b00}; cnt <= 0; if_valid <= 0.
  - state -> FETCH if fetch_en, else IDLE.
  - No instruction from before the redirect is ever presented afterwards.
  - If redirect and handshake occur in the same cycle, the handshake counts as accepted; the pc increment is discarded.
- Wrap-around:
  - pc is a 32-bit modular add.
  - mem_addr uses only pc[AW+1:2], so word MEM_SIZE-1 is followed by word 0 (pc 0x3FC -> 0x400 maps to word 0 for MEM_SIZE=256).
- Throughput is one instruction per WAIT_CYCLES+2 cycles when if_ready is held high. No overlap of fetch with OUT.
- The block never writes memory.
- rst asserted mid-fetch or mid-OUT returns all state to reset values on that edge.

Decomposition:
- Shared package/header (fetch_defs):
  - FSM state encodings (IDLE=2'd0, FETCH=2'd1, OUT=2'd2).
  - RESET_PC default.
  - INSTR_NOP = 32'h0000_0000.
- No sub-module. The wait counter and FSM are small enough to stay inline; the memory is instantiated only in the testbench/top.

Test Plan:
- Reset, then fetch_en=1, if_ready=1, WAIT_CYCLES=1, memory words 212/213 = 32'h00001825/32'h24020001 -> if_valid first rises 2 cycles after FETCH entry with if_instr=32'h00001825, if_pc=32'h350. Next is 32'h24020001 at if_pc=32'h354, 3 cycles later.
- Backpressure: if_ready=0 for 5 cycles while if_valid=1 -> if_instr/if_pc unchanged and mem_read_en=0 throughout. After if_ready=1 for one cycle, the next fetch starts and pc=32'h358.
- Redirect during FETCH: redirect_pc=32'h3F1 on cycle cnt=0 -> mem_addr becomes 252 (bits [1:0] dropped). Next if_instr=32'h00001025 with if_pc=32'h3F0; the abandoned word is never presented.
- Wrap: redirect to 32'h3FC, accept two instructions -> if_pc 32'h3FC then 32'h400, and mem_addr goes 255 then 0.
- fetch_en low mid-FETCH -> state IDLE, mem_read_en=0 next cycle, pc unchanged. Re-asserting restarts the fetch of the same address.
- Sync reset asserted while if_valid=1 -> next edge if_valid=0, if_pc=0, mem_addr=212. No output appears until fetch_en is high.

Source files
------------

// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and
// the default reset PC and idle instruction value.
package fetch_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0350;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads one word from a fixed-latency
// instruction memory, and presents it to decode.
//
// Decode handshake: if_valid/if_instr/if_pc are held stable while if_valid is
// high; a transfer occurs on any rising edge where if_valid && if_ready.
// if_ready is ignored while if_valid is low. A redirect squashes any in-flight
// or held instruction; if it coincides with a transfer, that transfer still
// counts as accepted.
module instr_fetch_unit
  import fetch_defs::*;
#(
  parameter int unsigned MEM_WIDTH   = 32,
  parameter int unsigned MEM_SIZE    = 256,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 1,
  localparam int unsigned AW         = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 if_valid,
  output logic [MEM_WIDTH-1:0] if_instr,
  output logic [31:0]          if_pc,
  input  logic                 if_ready,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val,
  output fetch_state_e         dbg_state
);

  // Last wait-counter value; the memory data is captured when cnt reaches it.
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES);

  fetch_state_e         state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          pc_q, pc_d;
  logic                 if_valid_q, if_valid_d;
  logic [MEM_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [31:0]          if_pc_q, if_pc_d;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= MEM_WIDTH'(INSTR_NOP);
      if_pc_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Next-state logic; redirect overrides every state-specific decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (redirect_valid) begin
      // Masking keeps the target word-aligned; any pending capture is dropped.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      cnt_d      = 4'd0;
      if_valid_d = 1'b0;
      state_d    = fetch_en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch_en) begin
            state_d = ST_FETCH;
            cnt_d   = 4'd0;
          end
        end
        ST_FETCH: begin
          if (cnt_q == CNT_LAST) begin
            // Capture cycle completes regardless of fetch_en.
            if_instr_d = mem_read_val;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            cnt_d      = 4'd0;
            state_d    = ST_OUT;
          end else if (!fetch_en) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_OUT: begin
          if (if_valid_q && if_ready) begin
            if_valid_d = 1'b0;
            cnt_d      = 4'd0;
            state_d    = fetch_en ? ST_FETCH : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign mem_addr      = pc_q[AW+1:2];
  assign mem_read_en   = (state_q == ST_FETCH);
  assign mem_write_en  = 1'b0;
  assign mem_write_val = '0;

  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign dbg_state = state_q;

endmodule
